multi_button_counter: RTL
=========================

Name: multi_button_counter

Overview:
Parametrised, multi-channel successor to the single-button debounced counter. Each of N_CH raw button inputs is synchronised, debounced by a per-channel state machine, and counted up or down with a selectable wrap or saturate mode. Each channel also has a per-channel clear and a sticky overflow flag. The block sits between board push-buttons and LED/display logic on the 12 MHz system clock.

Parameters:
N_CH, 4, number of independent button channels
CNT_W, 8, width of each channel counter
DEB_CYCLES, 240000, consecutive stable cycles required to accept a level change (20 ms at 12 MHz; benches override to 16)
SATURATE, 0, 0 = counters wrap modulo 2^CNT_W; 1 = counters clamp at 0 / 2^CNT_W-1

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous assert, active-low
b_in  in  N_CH  raw button levels, asynchronous, 1 = pressed, bouncy
dir  in  N_CH  per-channel count direction, 0 = up, 1 = down; sampled on the press edge
clr  in  N_CH  synchronous per-channel clear of count and ovf
pressed  out  N_CH  debounced button level
press_pulse  out  N_CH  one-cycle strobe per accepted press
count  out  N_CH*CNT_W  channel i occupies bits [i*CNT_W +: CNT_W]
ovf  out  N_CH  sticky per channel, set on wrap or saturation attempt

Behaviour:
- Decided: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): all outputs 0; synchronisers 0; debounce counters 0; FSMs in RELEASED. Release of rst_n is not synchronised internally; the top level provides a clean deassert.
- Synchroniser: 2-flop per channel; output s[i].
- Per-channel FSM, debounce counter dc of width clog2(DEB_CYCLES+1):
  - RELEASED: if s=1, go to PRESS_WAIT with dc=1; else dc=0.
  - PRESS_WAIT: if s=0, return to RELEASED with dc=0. Else, if dc==DEB_CYCLES-1, go to PRESSED, set pressed=1, assert press_pulse for one cycle, update count. Otherwise dc++.
  - PRESSED: if s=0, go to RELEASE_WAIT with dc=1.
  - RELEASE_WAIT: if s=1, return to PRESSED with dc=0. Else, if dc==DEB_CYCLES-1, go to RELEASED with pressed=0 and no count change. Otherwise dc++.
- Latency: b_in rising before edge k and held → pressed, press_pulse and count change are all visible after edge k+1+DEB_CYCLES (DEB_CYCLES+2 edges). Release has the same latency and produces no strobe.
- Any bounce shorter than DEB_CYCLES restarts qualification. One accepted press increments exactly once.
- Count update on an accepted press:
  - dir=0 at max value: SATURATE=0 gives 0; SATURATE=1 holds max. Either way ovf set.
  - dir=1 at 0: SATURATE=0 gives max; SATURATE=1 holds 0. Either way ovf set.
  - Otherwise count ±1, ovf unchanged.
- clr[i]=1: count[i]←0, ovf[i]←0 on that edge. clr wins over a simultaneous press; press_pulse still fires. clr does not affect FSM or pressed.
- Channels are fully independent. Simultaneous presses on several channels all count in the same cycle.
- Reset mid-debounce discards progress. An input held high through reset release re-qualifies from zero and counts once.
- ovf stays set until clr or rst_n.

Test Plan:
(All scenarios use DEB_CYCLES=16, N_CH=4, CNT_W=8.)
1. Clean press on ch0: b_in=0001 held 40 cycles, then 0. Required: pressed[0] rises exactly 18 edges after the b_in change; one press_pulse[0]; count ch0=1, other channels 0; pressed[0] falls 18 edges after release.
2. Bounce: ch1 toggles 10 high / 5 low for 120 cycles, stays high 30 cycles, then bounces on release. Required: exactly one press_pulse[1], count ch1=1, no extra counts on release.
3. Wrap, SATURATE=0: 256 clean presses on ch2 with dir=0. Required: count=0, ovf[2]=1. Then clr[2] pulse: count=0, ovf=0. Then one press with dir=1: count=255, ovf=1.
4. Saturate, SATURATE=1: 300 up-presses on ch3. Required: count=255, ovf=1. Then 3 down-presses: 252, ovf still 1.
5. clr[0] asserted on the press_pulse cycle. Required: count ch0=0 and the pulse is seen. Separately, rst_n low for 3 cycles mid-PRESS_WAIT with b_in held high: all outputs 0 during reset; after release, count=1 after 18 edges.
6. All four channels pressed on the same cycle with dir=0101. Required: four simultaneous pulses; counts ch0=255 wrap/ovf, ch1=1, ch2=255, ch3=1 starting from cleared state.

Source files
------------

// File: rtl/multi_button_counter.sv
// Multi-channel debounced push-button counter: each channel is synchronised, debounced
// by a four-state FSM and drives an up/down counter that either wraps or saturates.
module multi_button_counter #(
  parameter int N_CH       = 4,
  parameter int CNT_W      = 8,
  parameter int DEB_CYCLES = 240000,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       b_in,
  input  logic [N_CH-1:0]       dir,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       pressed,
  output logic [N_CH-1:0]       press_pulse,
  output logic [N_CH*CNT_W-1:0] count,
  output logic [N_CH-1:0]       ovf
);
  localparam int DC_W = $clog2(DEB_CYCLES + 1);
  localparam logic [DC_W-1:0]  DC_LAST = DC_W'(DEB_CYCLES - 1);
  localparam logic [DC_W-1:0]  DC_ONE  = DC_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic [N_CH-1:0] sync_meta;
  logic [N_CH-1:0] sync_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      sync_meta <= b_in;
      sync_s    <= sync_meta;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_ch
      state_t           state;
      logic [DC_W-1:0]  dc;
      logic             pressed_reg;
      logic             pulse_reg;
      logic             ovf_reg;
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             accept;
      logic             at_limit;

      // Same condition the FSM uses to enter PRESSED, so the count moves on the strobe edge.
      assign accept = (state == PRESS_WAIT) && sync_s[gi] && (dc == DC_LAST);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state       <= RELEASED;
          dc          <= '0;
          pressed_reg <= 1'b0;
          pulse_reg   <= 1'b0;
        end else begin
          pulse_reg <= 1'b0;
          case (state)
            RELEASED: begin
              if (sync_s[gi]) begin
                state <= PRESS_WAIT;
                dc    <= DC_ONE;
              end else begin
                dc <= '0;
              end
            end
            PRESS_WAIT: begin
              if (!sync_s[gi]) begin
                state <= RELEASED;
                dc    <= '0;
              end else if (dc == DC_LAST) begin
                state       <= PRESSED;
                pressed_reg <= 1'b1;
                pulse_reg   <= 1'b1;
                dc          <= '0;
              end else begin
                dc <= dc + DC_ONE;
              end
            end
            PRESSED: begin
              if (!sync_s[gi]) begin
                state <= RELEASE_WAIT;
                dc    <= DC_ONE;
              end
            end
            RELEASE_WAIT: begin
              if (sync_s[gi]) begin
                state <= PRESSED;
                dc    <= '0;
              end else if (dc == DC_LAST) begin
                state       <= RELEASED;
                pressed_reg <= 1'b0;
                dc          <= '0;
              end else begin
                dc <= dc + DC_ONE;
              end
            end
            default: begin
              state <= RELEASED;
              dc    <= '0;
            end
          endcase
        end
      end

      // Modular +/-1 gives the wrap case for free; saturation just holds the value.
      always_comb begin
        at_limit = dir[gi] ? (cnt_reg == '0) : (cnt_reg == CNT_MAX);
        cnt_next = dir[gi] ? (cnt_reg - CNT_ONE) : (cnt_reg + CNT_ONE);
        if (at_limit && (SATURATE != 0)) begin
          cnt_next = cnt_reg;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (clr[gi]) begin
          cnt_reg <= '0;
          ovf_reg <= 1'b0;
        end else if (accept) begin
          cnt_reg <= cnt_next;
          if (at_limit) begin
            ovf_reg <= 1'b1;
          end
        end
      end

      assign pressed[gi]                 = pressed_reg;
      assign press_pulse[gi]             = pulse_reg;
      assign ovf[gi]                     = ovf_reg;
      assign count[gi*CNT_W +: CNT_W]    = cnt_reg;
    end
  endgenerate
endmodule
